adc_emulator: RTL and testbench



---
 rtl/adc_emulator_pkg.sv | 27 ++
 rtl/adc_emulator_lane.sv | 37 +++
 rtl/adc_emulator.sv | 138 +++++++++++++
 tb/tb_adc_emulator.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_emulator_pkg.sv
// Shared constants, pattern helper and FSM encoding for the ADC bank emulator.
package adc_emulator_pkg;

  localparam int adc_channels   = 8;
  localparam int adc_bits       = 24;
  localparam int adc_decimate   = 8;
  localparam int convert_cycles = 30;

  localparam logic [3:0] nib_a = 4'hA;
  localparam logic [3:0] nib_b = 4'hB;
  localparam logic [3:0] nib_c = 4'hC;
  localparam logic [3:0] nib_d = 4'hD;

  localparam int conv_cnt_w = $clog2(convert_cycles);
  localparam int dec_cnt_w  = $clog2(adc_decimate);

  typedef enum logic {
    ST_IDLE,
    ST_CONVERT
  } conv_state_e;

  // Self-identifying word: channel and word counter each appear twice.
  function automatic logic [31:0] adc_pattern(input logic [3:0] chan, input logic [3:0] count);
    return {chan, nib_a, count, nib_b, chan, nib_c, count, nib_d};
  endfunction

endpackage

// File: rtl/adc_emulator_lane.sv
// One SDOA lane: loads its channel pattern on SYNC rise, shifts left (MSB out) on SCKA rise.
module adc_emulator_lane
  import adc_emulator_pkg::*;
#(
  parameter int chan = 0
) (
  input  logic       capture_clk,
  input  logic       reset,
  input  logic       load,
  input  logic       shift,
  input  logic [3:0] count,
  output logic       sdo
);

  logic [adc_bits-1:0] sr_q, sr_d;

  // Load takes priority so a coincident SCKA rise never eats the new MSB.
  always_comb begin
    sr_d = sr_q;
    if (load) begin
      sr_d = adc_bits'(adc_pattern(4'(chan), count));
    end else if (shift) begin
      sr_d = {sr_q[adc_bits-2:0], 1'b0};
    end
  end

  always_ff @(posedge capture_clk or posedge reset) begin
    if (reset) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign sdo = sr_q[adc_bits-1];

endmodule

// File: rtl/adc_emulator.sv
// Multi-channel serial ADC bank emulator answering MCLK/SCKA/SYNC/SDI from the capture_clk domain.
// Optional ADC_EMULATOR_SDI_CAPTURE_EN adds SDI configuration capture (cfg_word/cfg_valid).
module adc_emulator
  import adc_emulator_pkg::*;
(
  input  logic                    capture_clk,
  input  logic                    reset,
  input  logic                    adc_mclk,
  input  logic                    adc_scka,
  input  logic                    adc_sync,
  input  logic                    adc_sdi,
  output logic [adc_channels-1:0] adc_sdoa,
  output logic                    adc_drl
`ifdef ADC_EMULATOR_SDI_CAPTURE_EN
  ,
  output logic [31:0]             cfg_word,
  output logic                    cfg_valid
`endif
);

  logic       mclk_q, scka_q, sync_q;
  logic       mclk_rise, scka_rise, sync_rise;
  logic [3:0] count_q, count_d;

  assign mclk_rise = adc_mclk & ~mclk_q;
  assign scka_rise = adc_scka & ~scka_q;
  assign sync_rise = adc_sync & ~sync_q;

  always_comb begin
    count_d = count_q;
    if (sync_rise) begin
      count_d = count_q + 4'd1;
    end
  end

  always_ff @(posedge capture_clk or posedge reset) begin
    if (reset) begin
      mclk_q  <= 1'b0;
      scka_q  <= 1'b0;
      sync_q  <= 1'b0;
      count_q <= 4'd1;
    end else begin
      mclk_q  <= adc_mclk;
      scka_q  <= adc_scka;
      sync_q  <= adc_sync;
      count_q <= count_d;
    end
  end

  // Lanes load with the pre-increment counter value.
  for (genvar c = 0; c < adc_channels; c++) begin : g_lane
    adc_emulator_lane #(.chan(c)) u_lane (
      .capture_clk (capture_clk),
      .reset       (reset),
      .load        (sync_rise),
      .shift       (scka_rise),
      .count       (count_q),
      .sdo         (adc_sdoa[c])
    );
  end

  conv_state_e           state_q;
  logic [conv_cnt_w-1:0] conv_cnt_q;
  logic [dec_cnt_w-1:0]  dec_cnt_q;
  logic                  drl_q;

  // MCLK rises while converting are overruns and are dropped.
  always_ff @(posedge capture_clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      conv_cnt_q <= '0;
      dec_cnt_q  <= '0;
      drl_q      <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (mclk_rise) begin
            state_q    <= ST_CONVERT;
            conv_cnt_q <= conv_cnt_w'(convert_cycles - 1);
            drl_q      <= 1'b1;
          end
        end
        ST_CONVERT: begin
          if (conv_cnt_q == '0) begin
            state_q <= ST_IDLE;
            if (dec_cnt_q == dec_cnt_w'(adc_decimate - 1)) begin
              dec_cnt_q <= '0;
              drl_q     <= 1'b0;
            end else begin
              dec_cnt_q <= dec_cnt_q + 1'b1;
            end
          end else begin
            conv_cnt_q <= conv_cnt_q - 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign adc_drl = drl_q;

`ifdef ADC_EMULATOR_SDI_CAPTURE_EN
  logic [31:0] cfg_word_q, cfg_word_d;
  logic        cfg_valid_q, cfg_valid_d;

  // Capture runs only until the first conversion start after reset.
  always_comb begin
    cfg_word_d  = cfg_word_q;
    cfg_valid_d = cfg_valid_q;
    if (!cfg_valid_q) begin
      if (scka_rise) begin
        cfg_word_d = {cfg_word_q[30:0], adc_sdi};
      end
      if (mclk_rise) begin
        cfg_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge capture_clk or posedge reset) begin
    if (reset) begin
      cfg_word_q  <= '0;
      cfg_valid_q <= 1'b0;
    end else begin
      cfg_word_q  <= cfg_word_d;
      cfg_valid_q <= cfg_valid_d;
    end
  end

  assign cfg_word  = cfg_word_q;
  assign cfg_valid = cfg_valid_q;
`else
  logic sdi_unused;
  assign sdi_unused = adc_sdi;
`endif

endmodule

// File: tb/tb_adc_emulator.sv
// Scoreboard bench for adc_emulator; covers ADC_EMULATOR_SDI_CAPTURE_EN when that macro is defined.
module tb_adc_emulator;

  localparam int NCH   = 8;
  localparam int NBITS = 24;
  localparam int CONV  = 30;
  localparam int DEC   = 8;

  logic           capture_clk = 1'b0;
  logic           reset = 1'b0;
  logic           adc_mclk = 1'b0;
  logic           adc_scka = 1'b0;
  logic           adc_sync = 1'b0;
  logic           adc_sdi = 1'b0;
  logic [NCH-1:0] adc_sdoa;
  logic           adc_drl;
`ifdef ADC_EMULATOR_SDI_CAPTURE_EN
  logic [31:0]    cfg_word;
  logic           cfg_valid;
`endif

  adc_emulator dut (
    .capture_clk (capture_clk),
    .reset       (reset),
    .adc_mclk    (adc_mclk),
    .adc_scka    (adc_scka),
    .adc_sync    (adc_sync),
    .adc_sdi     (adc_sdi),
    .adc_sdoa    (adc_sdoa),
    .adc_drl     (adc_drl)
`ifdef ADC_EMULATOR_SDI_CAPTURE_EN
    ,
    .cfg_word    (cfg_word),
    .cfg_valid   (cfg_valid)
`endif
  );

  always #5 capture_clk = ~capture_clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge capture_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_event(input string name);
    checks++;
    errors++;
    $display("FAIL %s at cycle %0d", name, cyc);
  endtask

  // Reference model: words held whole, output bit chosen by shift index.
  int             m_count;
  logic [31:0]    m_word [NCH];
  int             m_shift;
  int             m_busy_until;
  int             m_conv;
  bit             m_drl_low;
  logic [NCH-1:0] sdo_exp_q [$];
  int             fall_q [$];
  int             rise_q [$];

  function automatic logic [31:0] pattern(input int ch, input int cnt);
    logic [31:0] p;
    p = 32'(ch) * 32'h1000_0000 + 32'h0A00_0000 + 32'(cnt) * 32'h0010_0000 + 32'h000B_0000
      + 32'(ch) * 32'h0000_1000 + 32'h0000_0C00 + 32'(cnt) * 32'h0000_0010 + 32'h0000_000D;
    return p % (32'd1 << NBITS);
  endfunction

  function automatic logic [NCH-1:0] model_sdo();
    logic [NCH-1:0] v;
    v = '0;
    for (int c = 0; c < NCH; c++) begin
      if (m_shift < NBITS) v[c] = m_word[c][NBITS-1-m_shift];
    end
    return v;
  endfunction

  task automatic model_reset();
    m_count = 1;
    for (int c = 0; c < NCH; c++) m_word[c] = '0;
    m_shift = NBITS;
    m_busy_until = 0;
    m_conv = 0;
    m_drl_low = 0;
  endtask

  task automatic model_mclk(input int c);
    if (c >= m_busy_until) begin
      m_busy_until = c + CONV + 1;
      m_conv++;
      if (m_drl_low) begin
        rise_q.push_back(c);
        m_drl_low = 0;
      end
      if (m_conv % DEC == 0) begin
        fall_q.push_back(c + CONV);
        m_drl_low = 1;
      end
    end
  endtask

  task automatic drive(input bit do_sync, input bit do_scka, input bit sdi);
    @(negedge capture_clk);
    adc_sync = do_sync;
    adc_scka = do_scka;
    adc_sdi  = sdi;
    if (do_sync) begin
      for (int c = 0; c < NCH; c++) m_word[c] = pattern(c, m_count);
      m_count = (m_count + 1) % 16;
      m_shift = 0;
    end else if (do_scka) begin
      if (m_shift < 1000) m_shift++;
    end
    if (do_sync || do_scka) sdo_exp_q.push_back(model_sdo());
    @(negedge capture_clk);
    adc_sync = 1'b0;
    adc_scka = 1'b0;
  endtask

  task automatic mclk_pulse();
    @(negedge capture_clk);
    adc_mclk = 1'b1;
    model_mclk(cyc + 1);
    @(negedge capture_clk);
    adc_mclk = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge capture_clk);
    reset = 1'b1;
    model_reset();
    @(negedge capture_clk);
    reset = 1'b0;
  endtask

  task automatic read_word(input int ch, output logic [NBITS-1:0] w);
    drive(1'b1, 1'b0, 1'b0);
    w[NBITS-1] = adc_sdoa[ch];
    for (int i = NBITS - 2; i >= 0; i--) begin
      drive(1'b0, 1'b1, 1'b0);
      w[i] = adc_sdoa[ch];
    end
  endtask

  // SDOA monitor: after every edge carrying a SYNC or SCKA rise, compare against the queue.
  initial begin
    bit ps, pk, sr, kr;
    ps = 0;
    pk = 0;
    forever begin
      @(posedge capture_clk);
      sr = adc_sync && !ps;
      kr = adc_scka && !pk;
      ps = adc_sync;
      pk = adc_scka;
      #1;
      if (!reset && (sr || kr)) begin
        if (sdo_exp_q.size() == 0) fail_event("sdoa_unexpected_update");
        else check("sdoa", 32'(adc_sdoa), 32'(sdo_exp_q.pop_front()));
      end
    end
  end

  // DRL monitor: every transition must match a scheduled fall or rise cycle.
  initial begin
    logic prev;
    prev = 1'b1;
    forever begin
      @(negedge capture_clk);
      if (!reset && (adc_drl === 1'b0 || adc_drl === 1'b1) && adc_drl !== prev) begin
        if (adc_drl === 1'b0) begin
          if (fall_q.size() == 0) fail_event("drl_fall_unexpected");
          else check("drl_fall_cycle", 32'(cyc), 32'(fall_q.pop_front()));
        end else begin
          if (rise_q.size() == 0) fail_event("drl_rise_unexpected");
          else check("drl_rise_cycle", 32'(cyc), 32'(rise_q.pop_front()));
        end
        prev = adc_drl;
      end
    end
  end

  initial begin
    logic [NBITS-1:0] w;
    int r;
    model_reset();
    #2 reset = 1'b1;
    repeat (3) @(negedge capture_clk);
    check("reset_sdoa", 32'(adc_sdoa), 32'h0);
    check("reset_drl", 32'(adc_drl), 32'h1);
`ifdef ADC_EMULATOR_SDI_CAPTURE_EN
    check("reset_cfg_word", cfg_word, 32'h0);
    check("reset_cfg_valid", 32'(cfg_valid), 32'h0);
`endif
    reset = 1'b0;

    // First word after reset on channel 2, count 1.
    read_word(2, w);
    check("ch2_word", 32'(w), 32'h001B_2C1D);
    check("ch2_first8", 32'(w[23:16]), 32'h1B);
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b0);

    // Abandon a word mid-shift with reset.
    drive(1'b1, 1'b0, 1'b0);
    repeat (5) drive(1'b0, 1'b1, 1'b0);
    do_reset();
    @(negedge capture_clk);
    check("midword_reset_sdoa", 32'(adc_sdoa), 32'h0);

    // Sixteen words: counter runs 1..15 then wraps to 0.
    for (int k = 0; k < 16; k++) begin
      read_word(0, w);
      check("wrap_count_nibble", 32'(w[23:20]), 32'((k + 1) % 16));
      check("wrap_b_nibble", 32'(w[19:16]), 32'hB);
      check("wrap_d_nibble", 32'(w[3:0]), 32'hD);
    end

    // Coincident SYNC and SCKA: load only, word still needs 24 shifts to drain.
    drive(1'b1, 1'b1, 1'b0);
    repeat (NBITS - 1) drive(1'b0, 1'b1, 1'b0);
    check("coincident_lsb_all_ch", 32'(adc_sdoa), 32'hFF);
    drive(1'b0, 1'b1, 1'b0);
    check("coincident_drained", 32'(adc_sdoa), 32'h0);

    // Randomized pin traffic.
    for (int k = 0; k < 400; k++) begin
      r = $urandom_range(0, 9);
      if (r == 0) drive(1'b1, 1'b0, 1'($urandom));
      else if (r == 1) drive(1'b1, 1'b1, 1'($urandom));
      else if (r == 9) @(negedge capture_clk);
      else drive(1'b0, 1'b1, 1'($urandom));
    end

`ifdef ADC_EMULATOR_SDI_CAPTURE_EN
    do_reset();
    begin
      logic [31:0] cfg_pat;
      cfg_pat = 32'hDEADBEEF;
      for (int i = 31; i >= 0; i--) drive(1'b0, 1'b1, cfg_pat[i]);
    end
    mclk_pulse();
    @(negedge capture_clk);
    check("cfg_word", cfg_word, 32'hDEADBEEF);
    check("cfg_valid", 32'(cfg_valid), 32'h1);
    repeat (6) drive(1'b0, 1'b1, 1'($urandom));
    check("cfg_word_frozen", cfg_word, 32'hDEADBEEF);
    repeat (CONV + 4) @(negedge capture_clk);
`endif

    // Decimation: only the 8th conversion drops DRL; next start raises it.
    for (int k = 0; k < DEC + 1; k++) begin
      mclk_pulse();
      repeat (CONV + 2) @(negedge capture_clk);
    end
    check("drl_low_after_fall_seen", 32'(fall_q.size()), 32'h0);

    // Overrun pulse inside a conversion must be ignored.
    for (int k = 0; k < DEC - 1; k++) begin
      mclk_pulse();
      if (k == 2) begin
        repeat (8) @(negedge capture_clk);
        mclk_pulse();
      end
      repeat (CONV + 2) @(negedge capture_clk);
    end

    // Random spacing, including overruns.
    for (int k = 0; k < 20; k++) begin
      mclk_pulse();
      repeat ($urandom_range(3, 45)) @(negedge capture_clk);
    end
    repeat (CONV + 5) @(negedge capture_clk);

    if (sdo_exp_q.size() != 0) fail_event("sdoa_expected_updates_missing");
    if (fall_q.size() != 0) fail_event("drl_fall_missing");
    if (rise_q.size() != 0) fail_event("drl_rise_missing");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
